core_sequencer: RTL and testbench

Instruction sequencer for the GPU cores. It fetches 16-bit opcodes from a synchronous program memory and broadcasts each one on the shared `opcode`/`execute` bus to all cores. It interprets sequencer-control bits inside misc-class opcodes: loop setup, loop branch and program end. It sits between the host/frame logic, which pulses `start` once per pixel or work item, and the core array.

---
 rtl/core_sequencer.sv | 160 ++++++++++++++++
 tb/tb_core_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: fetches 16-bit opcodes from a synchronous program memory and
// broadcasts them to the core array. It also interprets the sequencer-control
// field of misc-class opcodes (SETLOOP / LOOP / END).
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin program at address 0 (ignored while busy)
//   hold         stall fetch (sampled only in FETCH)
//   prog_addr    program memory read address (mirrors pc)
//   prog_data    program memory read data, valid one cycle after prog_addr
//   opcode       registered opcode broadcast to the cores
//   execute      registered one-cycle strobe qualifying opcode
//   busy         program running (FETCH or DECODE)
//   done         one-cycle pulse when END retires
//   pc           current program counter
module core_sequencer #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned LOOP_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hold,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [15:0]           prog_data,
  output logic [15:0]           opcode,
  output logic                  execute,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] pc
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2
  } state_t;

  localparam logic [1:0] CLASS_MISC   = 2'b11;
  localparam logic [1:0] CTRL_PLAIN   = 2'b00;
  localparam logic [1:0] CTRL_END     = 2'b01;
  localparam logic [1:0] CTRL_SETLOOP = 2'b10;
  localparam logic [1:0] CTRL_LOOP    = 2'b11;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [LOOP_WIDTH-1:0] r_loop_cnt;
  logic [15:0]           r_opcode;
  logic                  r_execute;
  logic                  r_done;
  logic                  r_busy;

  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [LOOP_WIDTH-1:0] w_loop_nxt;
  logic [15:0]           w_opcode_nxt;
  logic                  w_execute_nxt;
  logic                  w_done_nxt;
  logic                  w_is_misc;
  logic [1:0]            w_ctrl;

  // pc wraps naturally at 2^ADDR_WIDTH
  assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);
  assign w_is_misc = (prog_data[15:14] == CLASS_MISC);
  assign w_ctrl    = prog_data[7:6];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_loop_cnt <= '0;
      r_opcode   <= 16'h0000;
      r_execute  <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_loop_cnt <= w_loop_nxt;
      r_opcode   <= w_opcode_nxt;
      r_execute  <= w_execute_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state, decode and issue logic
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_loop_nxt    = r_loop_cnt;
    w_opcode_nxt  = r_opcode;
    w_execute_nxt = 1'b0;
    w_done_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = '0;
          w_loop_nxt  = '0;
        end
      end

      S_FETCH: begin
        if (!hold) begin
          w_state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        w_state_nxt   = S_FETCH;
        w_pc_nxt      = w_pc_inc;
        w_opcode_nxt  = prog_data;
        w_execute_nxt = 1'b1;
        if (w_is_misc) begin
          case (w_ctrl)
            CTRL_END: begin
              // END is consumed by the sequencer, never broadcast
              w_state_nxt   = S_IDLE;
              w_pc_nxt      = r_pc;
              w_opcode_nxt  = r_opcode;
              w_execute_nxt = 1'b0;
              w_done_nxt    = 1'b1;
            end
            CTRL_SETLOOP: begin
              w_loop_nxt = prog_data[LOOP_WIDTH-1:0];
            end
            CTRL_LOOP: begin
              if (r_loop_cnt != '0) begin
                w_loop_nxt = r_loop_cnt - LOOP_WIDTH'(1);
                w_pc_nxt   = prog_data[ADDR_WIDTH-1:0];
              end
            end
            CTRL_PLAIN: begin
              w_pc_nxt = w_pc_inc;
            end
            default: begin
              w_pc_nxt = w_pc_inc;
            end
          endcase
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign prog_addr = r_pc;
  assign pc        = r_pc;
  assign opcode    = r_opcode;
  assign execute   = r_execute;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus pushes expected issues
// (opcode, pc after issue) into a queue, a negedge monitor pops and compares.
module tb_core_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        hold;
  logic [5:0]  prog_addr;
  logic [15:0] prog_data;
  logic [15:0] opcode;
  logic        execute;
  logic        busy;
  logic        done;
  logic [5:0]  pc;

  logic        start2;
  logic [1:0]  prog_addr2;
  logic [15:0] prog_data2;
  logic [15:0] opcode2;
  logic        execute2;
  logic        busy2;
  logic        done2;
  logic [1:0]  pc2;

  logic [15:0] mem  [64];
  logic [15:0] mem2 [4];

  typedef struct packed {
    logic [15:0] op;
    logic [5:0]  pc;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_issue2 = 0;
  int exp_pc2 = 1;
  int cyc = 0;
  logic prev_exec = 1'b0;

  core_sequencer #(.ADDR_WIDTH(6), .LOOP_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .prog_addr(prog_addr), .prog_data(prog_data), .opcode(opcode),
    .execute(execute), .busy(busy), .done(done), .pc(pc)
  );

  core_sequencer #(.ADDR_WIDTH(2), .LOOP_WIDTH(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .hold(1'b0),
    .prog_addr(prog_addr2), .prog_data(prog_data2), .opcode(opcode2),
    .execute(execute2), .busy(busy2), .done(done2), .pc(pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memories
  always @(posedge clk) prog_data  <= mem[prog_addr];
  always @(posedge clk) prog_data2 <= mem2[prog_addr2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Main scoreboard monitor
  always @(negedge clk) begin
    if (execute === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_execute: got opcode %h pc %h expected no issue", opcode, pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_opcode", 32'(opcode), 32'(e.op));
        chk("issue_pc", 32'(pc), 32'(e.pc));
      end
      chk("execute_not_back_to_back", 32'(prev_exec), 32'(0));
    end
    if (done === 1'b1) begin
      n_done++;
      chk("done_busy_low", 32'(busy), 32'(0));
    end
    prev_exec = execute;
  end

  // Wrap-around monitor for the 2-bit-address instance
  always @(negedge clk) begin
    if (execute2 === 1'b1) begin
      chk("wrap_pc", 32'(pc2), 32'(exp_pc2));
      chk("wrap_opcode", 32'(opcode2), 32'h0011);
      chk("wrap_busy", 32'(busy2), 32'(1));
      exp_pc2 = (exp_pc2 + 1) % 4;
      n_issue2++;
    end
  end

  task automatic push(input logic [15:0] op, input logic [5:0] p);
    exp_t e;
    e.op = op;
    e.pc = p;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  // start sampled at edge 0; cycle 1 is the one following it
  task automatic start_prog();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done(input string name);
    int k;
    int d0;
    k = 0;
    d0 = n_done;
    while (done !== 1'b1 && k < 60) begin
      next_cycle();
      k++;
    end
    chk({name, "_done_seen"}, 32'(done), 32'(1));
    chk({name, "_busy_at_done"}, 32'(busy), 32'(0));
    chk({name, "_all_issued"}, 32'(sb.size()), 32'(0));
    next_cycle();
    chk({name, "_done_one_cycle"}, 32'(done), 32'(0));
    chk({name, "_done_count"}, 32'(n_done - d0), 32'(1));
  endtask

  initial begin
    int d0;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    hold   = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) mem2[i] = 16'h0011;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_opcode", 32'(opcode), 32'h0000);
    chk("rst_execute", 32'(execute), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_pc", 32'(pc), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'(0));

    // Basic program: load, mul, END
    mem[0] = 16'h0105; mem[1] = 16'h4006; mem[2] = 16'hC040;
    push(16'h0105, 6'd1);
    push(16'h4006, 6'd2);
    start_prog();
    next_cycle(); chk("basic_c1_busy", 32'(busy), 32'(1));
    chk("basic_c1_exec", 32'(execute), 32'(0));
    next_cycle(); chk("basic_c2_exec", 32'(execute), 32'(0));
    next_cycle(); chk("basic_c3_exec", 32'(execute), 32'(1));
    chk("basic_c3_opcode", 32'(opcode), 32'h0105);
    next_cycle(); chk("basic_c4_exec", 32'(execute), 32'(0));
    next_cycle(); chk("basic_c5_exec", 32'(execute), 32'(1));
    chk("basic_c5_opcode", 32'(opcode), 32'h4006);
    wait_done("basic");

    // Loop: SETLOOP 2, shift, LOOP->1, END
    mem[0] = 16'hC082; mem[1] = 16'h8000; mem[2] = 16'hC0C1; mem[3] = 16'hC040;
    push(16'hC082, 6'd1);
    push(16'h8000, 6'd2); push(16'hC0C1, 6'd1);
    push(16'h8000, 6'd2); push(16'hC0C1, 6'd1);
    push(16'h8000, 6'd2); push(16'hC0C1, 6'd3);
    start_prog();
    wait_done("loop");
    chk("loop_final_cnt", 32'(dut.r_loop_cnt), 32'(0));

    // Hold for 4 cycles in FETCH of addr1
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'hC040; mem[3] = 16'h0000;
    push(16'h0001, 6'd1);
    push(16'h0002, 6'd2);
    start_prog();
    next_cycle(); next_cycle(); next_cycle();
    chk("hold_c3_exec", 32'(execute), 32'(1));
    hold = 1'b1;
    for (int c = 4; c <= 7; c++) begin
      next_cycle();
      chk($sformatf("hold_c%0d_exec", c), 32'(execute), 32'(0));
    end
    hold = 1'b0;
    next_cycle(); chk("hold_c8_exec", 32'(execute), 32'(0));
    next_cycle(); chk("hold_c9_exec", 32'(execute), 32'(1));
    chk("hold_c9_opcode", 32'(opcode), 32'h0002);
    wait_done("hold");

    // Store passthrough, start while busy ignored
    mem[0] = 16'hC300; mem[1] = 16'h0010; mem[2] = 16'hC040;
    push(16'hC300, 6'd1);
    push(16'h0010, 6'd2);
    start_prog();
    next_cycle(); next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    chk("store_c3_exec", 32'(execute), 32'(1));
    chk("store_c3_pc", 32'(pc), 32'(1));
    chk("store_c3_busy", 32'(busy), 32'(1));
    wait_done("store");

    // Wrap-around on the 2-bit instance
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    begin
      int k;
      k = 0;
      while (n_issue2 < 5 && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("wrap_issue_count", 32'(n_issue2 >= 5), 32'(1));
      chk("wrap_done_never", 32'(done2), 32'(0));
    end

    // Asynchronous reset during DECODE
    mem[0] = 16'h0105; mem[1] = 16'h4006; mem[2] = 16'hC040;
    start_prog();
    next_cycle(); next_cycle();
    rst_n = 1'b0;
    #1;
    chk("arst_opcode", 32'(opcode), 32'h0000);
    chk("arst_execute", 32'(execute), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_pc", 32'(pc), 32'(0));
    chk("arst_busy2", 32'(busy2), 32'(0));
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    d0 = n_done;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      chk("post_rst_execute", 32'(execute), 32'(0));
      chk("post_rst_done", 32'(done), 32'(0));
    end
    chk("post_rst_no_done", 32'(n_done - d0), 32'(0));
    chk("post_rst_queue", 32'(sb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
